cpumc_arb: RTL and testbench



---
 rtl/nes_bus_pkg.sv | 21 ++
 rtl/sat_cnt.sv | 34 +++
 rtl/cpumc_arb.sv | 165 ++++++++++++++++
 tb/tb_cpumc_arb.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus definitions: arbiter state encodings, bus owner ids and bus widths.
package nes_bus_pkg;

    localparam int A_W = 16;
    localparam int D_W = 8;

    localparam logic [2:0] ST_CPU_OWN  = 3'd0;
    localparam logic [2:0] ST_DRAIN    = 3'd1;
    localparam logic [2:0] ST_HCI_IDLE = 3'd2;
    localparam logic [2:0] ST_HCI_ACC  = 3'd3;
    localparam logic [2:0] ST_RELEASE  = 3'd4;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_HCI = 1'b1;

    // The CPU drives the bus only in CPU_OWN; every other state presents the hci latch.
    function automatic logic bus_owner(input logic [2:0] st);
        return (st == ST_CPU_OWN) ? OWNER_CPU : OWNER_HCI;
    endfunction

endpackage

// File: rtl/sat_cnt.sv
// Generic saturating up-counter with synchronous clear (clear wins over increment).
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         nrst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, else increment until all ones, then hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    // Counter register, synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!nrst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cpumc_arb.sv
// CPU memory bus arbiter: rp2a03 is the default owner, the hci debug port gets the bus
// only after the CPU is stalled and drained, and each hci strobe makes exactly one bus
// access so side-effecting PPU registers fire once.
// Optional feature macro CPUMC_ARB_STALL_CNT_EN adds stall_cnt_out (CPU stall cycle count).
module cpumc_arb
    import nes_bus_pkg::*;
#(
    parameter int READ_LAT  = 1,
    parameter int DRAIN_CYC = 1
) (
    input  logic           clk_in,
    input  logic           nrst_in,
    input  logic [A_W-1:0] cpu_a_in,
    input  logic           cpu_r_nw_in,
    input  logic [D_W-1:0] cpu_d_in,
    output logic           cpu_rdy_out,
    output logic [D_W-1:0] cpu_d_out,
    input  logic           hci_req_in,
    input  logic           hci_stb_in,
    input  logic [A_W-1:0] hci_a_in,
    input  logic           hci_r_nw_in,
    input  logic [D_W-1:0] hci_d_in,
    output logic           hci_gnt_out,
    output logic           hci_ack_out,
    output logic [D_W-1:0] hci_d_out,
    output logic [A_W-1:0] mc_a_out,
    output logic           mc_r_nw_out,
    output logic [D_W-1:0] mc_d_out,
    input  logic [D_W-1:0] mc_d_in
`ifdef CPUMC_ARB_STALL_CNT_EN
    ,
    output logic [15:0]    stall_cnt_out
`endif
);

    // Last cycle index of the drain wait and of a read access (both count from 0).
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYC - 1);
    localparam logic [7:0] RD_LAST    = 8'(READ_LAT - 1);

    logic [2:0]     state_q, state_d;
    logic [7:0]     cnt_q,   cnt_d;
    logic [A_W-1:0] a_q,     a_d;
    logic           rnw_q,   rnw_d;
    logic [D_W-1:0] wd_q,    wd_d;
    logic [D_W-1:0] rd_q,    rd_d;
    logic           ack_q,   ack_d;
    logic           acc_done;

    // A write occupies one ACC cycle; a read holds its address for READ_LAT cycles
    // and samples mc_d_in at the end of the last one.
    assign acc_done = rnw_q ? (cnt_q == RD_LAST) : 1'b1;

    // Ownership FSM and access latch next-state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        rnw_d   = rnw_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        ack_d   = 1'b0;
        case (state_q)
            ST_CPU_OWN: begin
                if (hci_req_in) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                if (!hci_req_in)
                    state_d = ST_RELEASE;
                else if (cnt_q == DRAIN_LAST)
                    state_d = ST_HCI_IDLE;
                else
                    cnt_d = cnt_q + 8'd1;
            end
            ST_HCI_IDLE: begin
                // A strobe in the same cycle as a request drop is still honoured.
                if (hci_stb_in) begin
                    a_d     = hci_a_in;
                    rnw_d   = hci_r_nw_in;
                    wd_d    = hci_d_in;
                    cnt_d   = '0;
                    state_d = ST_HCI_ACC;
                end else if (!hci_req_in) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_HCI_ACC: begin
                // Strobes are ignored here; a request drop takes effect after the ack.
                if (acc_done) begin
                    ack_d = 1'b1;
                    if (rnw_q)
                        rd_d = mc_d_in;
                    state_d = hci_req_in ? ST_HCI_IDLE : ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RELEASE: state_d = ST_CPU_OWN;
            default:    state_d = ST_CPU_OWN;
        endcase
    end

    // State and latch registers; reset abandons any pending access without an ack.
    always_ff @(posedge clk_in) begin
        if (!nrst_in) begin
            state_q <= ST_CPU_OWN;
            cnt_q   <= '0;
            a_q     <= '0;
            rnw_q   <= 1'b1;
            wd_q    <= '0;
            rd_q    <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            rnw_q   <= rnw_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            ack_q   <= ack_d;
        end
    end

    // Bus mux: only the HCI_ACC cycle of a write may drive r_nw low outside CPU_OWN.
    always_comb begin
        if (bus_owner(state_q) == OWNER_CPU) begin
            mc_a_out    = cpu_a_in;
            mc_r_nw_out = cpu_r_nw_in;
            mc_d_out    = cpu_d_in;
        end else begin
            mc_a_out    = a_q;
            mc_r_nw_out = !((state_q == ST_HCI_ACC) && !rnw_q);
            mc_d_out    = wd_q;
        end
    end

    assign cpu_rdy_out = (state_q == ST_CPU_OWN);
    assign hci_gnt_out = (state_q == ST_HCI_IDLE) || (state_q == ST_HCI_ACC);
    assign hci_ack_out = ack_q;
    assign hci_d_out   = rd_q;
    assign cpu_d_out   = mc_d_in;

`ifdef CPUMC_ARB_STALL_CNT_EN
    logic req_q;

    // Previous request level, for rising-edge clear of the stall counter.
    always_ff @(posedge clk_in) begin
        if (!nrst_in)
            req_q <= 1'b0;
        else
            req_q <= hci_req_in;
    end

    sat_cnt #(.W(16)) u_stall_cnt (
        .clk_i  (clk_in),
        .nrst_i (nrst_in),
        .clr_i  (hci_req_in & ~req_q),
        .inc_i  (~cpu_rdy_out),
        .cnt_o  (stall_cnt_out)
    );
`endif

endmodule

// File: tb/tb_cpumc_arb.sv
// Directed self-checking bench for cpumc_arb (READ_LAT=1, DRAIN_CYC=1).
// Bus model: combinational read data (0x0010 -> 3C, 0x2002 -> 80), plus monitors that
// count hci-side bus writes and distinct PPU 0x2002 read accesses.
module tb_cpumc_arb;

    logic        clk_in = 1'b0;
    logic        nrst_in;
    logic [15:0] cpu_a_in;
    logic        cpu_r_nw_in;
    logic [7:0]  cpu_d_in;
    logic        cpu_rdy_out;
    logic [7:0]  cpu_d_out;
    logic        hci_req_in;
    logic        hci_stb_in;
    logic [15:0] hci_a_in;
    logic        hci_r_nw_in;
    logic [7:0]  hci_d_in;
    logic        hci_gnt_out;
    logic        hci_ack_out;
    logic [7:0]  hci_d_out;
    logic [15:0] mc_a_out;
    logic        mc_r_nw_out;
    logic [7:0]  mc_d_out;
    logic [7:0]  mc_d_in;
`ifdef CPUMC_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_out;
`endif

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int ppu_rd   = 0;
    logic ppu_prev = 1'b0;
    logic [15:0] wr_a = '0;
    logic [7:0]  wr_d = '0;

    cpumc_arb #(.READ_LAT(1), .DRAIN_CYC(1)) dut (
        .clk_in      (clk_in),
        .nrst_in     (nrst_in),
        .cpu_a_in    (cpu_a_in),
        .cpu_r_nw_in (cpu_r_nw_in),
        .cpu_d_in    (cpu_d_in),
        .cpu_rdy_out (cpu_rdy_out),
        .cpu_d_out   (cpu_d_out),
        .hci_req_in  (hci_req_in),
        .hci_stb_in  (hci_stb_in),
        .hci_a_in    (hci_a_in),
        .hci_r_nw_in (hci_r_nw_in),
        .hci_d_in    (hci_d_in),
        .hci_gnt_out (hci_gnt_out),
        .hci_ack_out (hci_ack_out),
        .hci_d_out   (hci_d_out),
        .mc_a_out    (mc_a_out),
        .mc_r_nw_out (mc_r_nw_out),
        .mc_d_out    (mc_d_out),
        .mc_d_in     (mc_d_in)
`ifdef CPUMC_ARB_STALL_CNT_EN
        ,
        .stall_cnt_out (stall_cnt_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    // WRAM / PPU read data model.
    always_comb begin
        mc_d_in = 8'h00;
        if (mc_a_out == 16'h0010) mc_d_in = 8'h3C;
        else if (mc_a_out == 16'h2002) mc_d_in = 8'h80;
    end

    // Monitors: hci-side bus writes, and new read accesses to the PPU status register.
    always @(posedge clk_in) begin
        if (nrst_in && !cpu_rdy_out && !mc_r_nw_out) begin
            wr_cnt <= wr_cnt + 1;
            wr_a   <= mc_a_out;
            wr_d   <= mc_d_out;
        end
        ppu_prev <= (mc_a_out == 16'h2002) && mc_r_nw_out && !cpu_rdy_out;
        if ((mc_a_out == 16'h2002) && mc_r_nw_out && !cpu_rdy_out && !ppu_prev)
            ppu_rd <= ppu_rd + 1;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        nrst_in = 1'b0; hci_req_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (cpu_rdy_out !== 1'b1) begin failures++; $display("FAIL reset_rdy cyc%0d got=%b exp=1", i, cpu_rdy_out); end
            checks++; if (hci_gnt_out !== 1'b0) begin failures++; $display("FAIL reset_gnt cyc%0d got=%b exp=0", i, hci_gnt_out); end
            checks++; if (hci_ack_out !== 1'b0) begin failures++; $display("FAIL reset_ack cyc%0d got=%b exp=0", i, hci_ack_out); end
            checks++; if (hci_d_out !== 8'h00) begin failures++; $display("FAIL reset_hci_d cyc%0d got=%h exp=00", i, hci_d_out); end
        end
        nrst_in = 1'b1; hci_req_in = 1'b0;
        tick();
    endtask

    task automatic test_grant();
        cpu_a_in = 16'h1234; cpu_r_nw_in = 1'b0; cpu_d_in = 8'h5A;
        #1;
        checks++; if (mc_a_out !== 16'h1234) begin failures++; $display("FAIL cpu_pass_a got=%h exp=1234", mc_a_out); end
        checks++; if (mc_r_nw_out !== 1'b0) begin failures++; $display("FAIL cpu_pass_rnw got=%b exp=0", mc_r_nw_out); end
        hci_req_in = 1'b1;                       // cycle 0
        tick();                                  // cycle 1: draining
        checks++; if (cpu_rdy_out !== 1'b0) begin failures++; $display("FAIL grant_rdy_c1 got=%b exp=0", cpu_rdy_out); end
        checks++; if (hci_gnt_out !== 1'b0) begin failures++; $display("FAIL grant_gnt_c1 got=%b exp=0", hci_gnt_out); end
        checks++; if (mc_r_nw_out !== 1'b1) begin failures++; $display("FAIL grant_rnw_c1 got=%b exp=1", mc_r_nw_out); end
        tick();                                  // cycle 2: granted
        checks++; if (hci_gnt_out !== 1'b1) begin failures++; $display("FAIL grant_gnt_c2 got=%b exp=1", hci_gnt_out); end
        checks++; if (cpu_rdy_out !== 1'b0) begin failures++; $display("FAIL grant_rdy_c2 got=%b exp=0", cpu_rdy_out); end
        checks++; if (mc_r_nw_out !== 1'b1) begin failures++; $display("FAIL grant_rnw_c2 got=%b exp=1", mc_r_nw_out); end
`ifdef CPUMC_ARB_STALL_CNT_EN
        checks++; if (stall_cnt_out !== 16'd1) begin failures++; $display("FAIL grant_stall got=%0d exp=1", stall_cnt_out); end
`endif
        cpu_r_nw_in = 1'b1;
    endtask

    task automatic test_write();
        int w0;
        w0 = wr_cnt;
        hci_stb_in = 1'b1; hci_a_in = 16'h0005; hci_d_in = 8'hA5; hci_r_nw_in = 1'b0;   // stb cycle
        tick();                                  // stb+1: bus write
        hci_stb_in = 1'b1; hci_a_in = 16'h0006; hci_d_in = 8'h11;                      // ignored strobe
        #1;
        checks++; if (mc_r_nw_out !== 1'b0) begin failures++; $display("FAIL wr_rnw got=%b exp=0", mc_r_nw_out); end
        checks++; if (mc_a_out !== 16'h0005) begin failures++; $display("FAIL wr_a got=%h exp=0005", mc_a_out); end
        checks++; if (mc_d_out !== 8'hA5) begin failures++; $display("FAIL wr_d got=%h exp=a5", mc_d_out); end
        checks++; if (hci_ack_out !== 1'b0) begin failures++; $display("FAIL wr_ack_early got=%b exp=0", hci_ack_out); end
        tick();                                  // stb+2: ack
        hci_stb_in = 1'b0;
        #1;
        checks++; if (hci_ack_out !== 1'b1) begin failures++; $display("FAIL wr_ack got=%b exp=1", hci_ack_out); end
        checks++; if (mc_r_nw_out !== 1'b1) begin failures++; $display("FAIL wr_rnw_after got=%b exp=1", mc_r_nw_out); end
        checks++; if (hci_d_out !== 8'h00) begin failures++; $display("FAIL wr_hci_d got=%h exp=00", hci_d_out); end
        tick();
        tick();
        checks++; if (hci_ack_out !== 1'b0) begin failures++; $display("FAIL wr_ack_pulse got=%b exp=0", hci_ack_out); end
        checks++; if (wr_cnt - w0 !== 1) begin failures++; $display("FAIL wr_count got=%0d exp=1", wr_cnt - w0); end
        checks++; if ({wr_a, wr_d} !== {16'h0005, 8'hA5}) begin failures++; $display("FAIL wr_bus got=%h/%h exp=0005/a5", wr_a, wr_d); end
    endtask

    task automatic test_read();
        int w0, p0;
        w0 = wr_cnt;
        hci_stb_in = 1'b1; hci_a_in = 16'h0010; hci_r_nw_in = 1'b1;
        tick();
        hci_stb_in = 1'b0;
        #1;
        checks++; if ({mc_a_out, mc_r_nw_out} !== {16'h0010, 1'b1}) begin failures++; $display("FAIL rd_bus got=%h/%b exp=0010/1", mc_a_out, mc_r_nw_out); end
        checks++; if (hci_ack_out !== 1'b0) begin failures++; $display("FAIL rd_ack_early got=%b exp=0", hci_ack_out); end
        tick();
        checks++; if (hci_ack_out !== 1'b1) begin failures++; $display("FAIL rd_ack got=%b exp=1", hci_ack_out); end
        checks++; if (hci_d_out !== 8'h3C) begin failures++; $display("FAIL rd_data got=%h exp=3c", hci_d_out); end
        tick();
        checks++; if ({hci_ack_out, hci_d_out} !== {1'b0, 8'h3C}) begin failures++; $display("FAIL rd_hold got=%b/%h exp=0/3c", hci_ack_out, hci_d_out); end
        p0 = ppu_rd;
        hci_stb_in = 1'b1; hci_a_in = 16'h2002; hci_r_nw_in = 1'b1;
        tick();
        hci_stb_in = 1'b0;
        tick();
        checks++; if ({hci_ack_out, hci_d_out} !== {1'b1, 8'h80}) begin failures++; $display("FAIL ppu_rd got=%b/%h exp=1/80", hci_ack_out, hci_d_out); end
        for (int i = 0; i < 4; i++) tick();
        checks++; if (ppu_rd - p0 !== 1) begin failures++; $display("FAIL ppu_rd_count got=%0d exp=1", ppu_rd - p0); end
        checks++; if (wr_cnt - w0 !== 0) begin failures++; $display("FAIL rd_no_write got=%0d exp=0", wr_cnt - w0); end
    endtask

    task automatic test_release();
        cpu_a_in = 16'h4016; cpu_r_nw_in = 1'b1;
        hci_stb_in = 1'b1; hci_a_in = 16'h0010; hci_r_nw_in = 1'b1;
        tick();                                  // read access in flight
        hci_stb_in = 1'b0; hci_req_in = 1'b0;
        tick();                                  // ack while releasing
        checks++; if (hci_ack_out !== 1'b1) begin failures++; $display("FAIL rel_ack got=%b exp=1", hci_ack_out); end
        checks++; if (hci_d_out !== 8'h3C) begin failures++; $display("FAIL rel_data got=%h exp=3c", hci_d_out); end
        checks++; if ({hci_gnt_out, cpu_rdy_out} !== 2'b00) begin failures++; $display("FAIL rel_gap got=%b%b exp=00", hci_gnt_out, cpu_rdy_out); end
        tick();
        checks++; if ({hci_gnt_out, cpu_rdy_out, hci_ack_out} !== 3'b010) begin failures++; $display("FAIL rel_cpu got=%b%b%b exp=010", hci_gnt_out, cpu_rdy_out, hci_ack_out); end
        checks++; if (mc_a_out !== 16'h4016) begin failures++; $display("FAIL rel_cpu_a got=%h exp=4016", mc_a_out); end
    endtask

    task automatic test_reset_mid();
        hci_req_in = 1'b1;
        tick();
        tick();
        checks++; if (hci_gnt_out !== 1'b1) begin failures++; $display("FAIL rst_mid_gnt got=%b exp=1", hci_gnt_out); end
        hci_stb_in = 1'b1; hci_a_in = 16'h0007; hci_d_in = 8'h11; hci_r_nw_in = 1'b0;
        tick();                                  // in HCI_ACC
        hci_stb_in = 1'b0; nrst_in = 1'b0;
        tick();
        checks++; if ({cpu_rdy_out, hci_gnt_out, hci_ack_out} !== 3'b100) begin failures++; $display("FAIL rst_mid got=%b%b%b exp=100", cpu_rdy_out, hci_gnt_out, hci_ack_out); end
`ifdef CPUMC_ARB_STALL_CNT_EN
        checks++; if (stall_cnt_out !== 16'd0) begin failures++; $display("FAIL rst_mid_stall got=%0d exp=0", stall_cnt_out); end
`endif
        nrst_in = 1'b1; hci_req_in = 1'b0;
        tick();
        checks++; if ({cpu_rdy_out, hci_ack_out} !== 2'b10) begin failures++; $display("FAIL rst_mid_noack got=%b%b exp=10", cpu_rdy_out, hci_ack_out); end
    endtask

    initial begin
        cpu_a_in = 16'h8000; cpu_r_nw_in = 1'b1; cpu_d_in = 8'h00;
        hci_req_in = 1'b0; hci_stb_in = 1'b0; hci_a_in = '0; hci_r_nw_in = 1'b1; hci_d_in = '0;
        nrst_in = 1'b0;
        test_reset();
        test_grant();
        test_write();
        test_read();
        test_release();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
